// File: rtl/iir_biquad_seq_if.sv
// Bundle between the biquad sequencer, its sample source/sink and the shared
// pipelined Q2.22 multiplier.
interface iir_biquad_seq_if #(
  parameter int unsigned DW = 24
);
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic [DW-1:0] b0;
  logic [DW-1:0] b1;
  logic [DW-1:0] b2;
  logic [DW-1:0] a1;
  logic [DW-1:0] a2;
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic          mul_valid;
  logic [DW-1:0] mul_p;
  logic          mul_p_valid;
  logic [DW-1:0] y_out;
  logic          out_valid;
  logic          sat;

  // Sequencer side.
  modport slave (
    input  clr, in_valid, x_in, b0, b1, b2, a1, a2, mul_p, mul_p_valid,
    output in_ready, mul_a, mul_b, mul_valid, y_out, out_valid, sat
  );

  // Environment side: sample source/sink plus multiplier.
  modport master (
    output clr, in_valid, x_in, b0, b1, b2, a1, a2, mul_p, mul_p_valid,
    input  in_ready, mul_a, mul_b, mul_valid, y_out, out_valid, sat
  );
endinterface

// File: rtl/iir_biquad_seq.sv
// Direct-form-I biquad controller: issues five coefficient x history pairs to a
// shared pipelined multiplier, accumulates the products and emits a saturated y[n].
module iir_biquad_seq #(
  parameter int unsigned DW    = 24,
  parameter int unsigned ACC_W = 28
) (
  input  logic           clk,
  input  logic           rst,
  iir_biquad_seq_if.slave bus_io
);
  localparam int unsigned NPAIR = 5;
  localparam int unsigned NADD  = 3;
  localparam int unsigned CW    = 3;
  localparam int unsigned EXT_W = ACC_W - DW;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(EXT_W + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(EXT_W + 1){1'b1}}, {(DW - 1){1'b0}}};
  localparam logic        [DW-1:0]    Y_MAX   = {1'b0, {(DW - 1){1'b1}}};
  localparam logic        [DW-1:0]    Y_MIN   = {1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             issue_q, issue_d;
  logic [CW-1:0]             pcnt_q, pcnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DW-1:0]             x_q, x_d;
  logic [DW-1:0]             coef_q [NPAIR];
  logic [DW-1:0]             coef_d [NPAIR];
  logic [DW-1:0]             x1_q, x1_d;
  logic [DW-1:0]             x2_q, x2_d;
  logic [DW-1:0]             y1_q, y1_d;
  logic [DW-1:0]             y2_q, y2_d;
  logic [DW-1:0]             mul_a_q, mul_a_d;
  logic [DW-1:0]             mul_b_q, mul_b_d;
  logic                      mul_valid_q, mul_valid_d;
  logic [DW-1:0]             y_q, y_d;
  logic                      out_valid_q, out_valid_d;
  logic                      sat_q, sat_d;

  logic [DW-1:0]             op_a_c;
  logic [DW-1:0]             op_b_c;
  logic signed [ACC_W-1:0]   prod_ext_c;
  logic signed [ACC_W-1:0]   sum_c;
  logic                      clip_hi_c;
  logic                      clip_lo_c;
  logic [DW-1:0]             ysat_c;

  // Operand pair for the issue slot; slot 0 is driven straight from the inputs at acceptance.
  always_comb begin
    op_a_c = coef_q[0];
    op_b_c = x_q;
    case (issue_q)
      CW'(1): begin
        op_a_c = coef_q[1];
        op_b_c = x1_q;
      end
      CW'(2): begin
        op_a_c = coef_q[2];
        op_b_c = x2_q;
      end
      CW'(3): begin
        op_a_c = coef_q[3];
        op_b_c = y1_q;
      end
      CW'(4): begin
        op_a_c = coef_q[4];
        op_b_c = y2_q;
      end
      default: begin
        op_a_c = coef_q[0];
        op_b_c = x_q;
      end
    endcase
  end

  // Feed-forward products are added, feedback products subtracted.
  always_comb begin
    prod_ext_c = {{EXT_W{bus_io.mul_p[DW-1]}}, bus_io.mul_p};
    sum_c      = (pcnt_q < CW'(NADD)) ? (acc_q + prod_ext_c) : (acc_q - prod_ext_c);
    clip_hi_c  = (sum_c > SAT_MAX);
    clip_lo_c  = (sum_c < SAT_MIN);
    if (clip_hi_c) begin
      ysat_c = Y_MAX;
    end else if (clip_lo_c) begin
      ysat_c = Y_MIN;
    end else begin
      ysat_c = sum_c[DW-1:0];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    pcnt_d      = pcnt_q;
    acc_d       = acc_q;
    x_d         = x_q;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_valid_d = 1'b0;
    y_d         = y_q;
    out_valid_d = 1'b0;
    sat_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_io.clr) begin
          x1_d = '0;
          x2_d = '0;
          y1_d = '0;
          y2_d = '0;
        end else if (bus_io.in_valid) begin
          x_d         = bus_io.x_in;
          coef_d[0]   = bus_io.b0;
          coef_d[1]   = bus_io.b1;
          coef_d[2]   = bus_io.b2;
          coef_d[3]   = bus_io.a1;
          coef_d[4]   = bus_io.a2;
          acc_d       = '0;
          pcnt_d      = '0;
          issue_d     = CW'(1);
          mul_valid_d = 1'b1;
          mul_a_d     = bus_io.b0;
          mul_b_d     = bus_io.x_in;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_q < CW'(NPAIR)) begin
          mul_valid_d = 1'b1;
          mul_a_d     = op_a_c;
          mul_b_d     = op_b_c;
          issue_d     = issue_q + CW'(1);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Products are counted in return order, which matches issue order.
    if ((state_q != S_IDLE) && bus_io.mul_p_valid) begin
      acc_d  = sum_c;
      pcnt_d = pcnt_q + CW'(1);
      if (pcnt_q == CW'(NPAIR - 1)) begin
        y_d         = ysat_c;
        out_valid_d = 1'b1;
        sat_d       = clip_hi_c | clip_lo_c;
        x2_d        = x1_q;
        x1_d        = x_q;
        y2_d        = y1_q;
        y1_d        = ysat_c;
        pcnt_d      = '0;
        state_d     = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_q     <= '0;
      pcnt_q      <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      coef_q      <= '{default: '0};
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_valid_q <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      pcnt_q      <= pcnt_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_valid_q <= mul_valid_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  // in_ready must drop in the same cycle clr is raised, so it is decoded from state and clr.
  assign bus_io.in_ready  = (state_q == S_IDLE) && !bus_io.clr;
  assign bus_io.mul_a     = mul_a_q;
  assign bus_io.mul_b     = mul_b_q;
  assign bus_io.mul_valid = mul_valid_q;
  assign bus_io.y_out     = y_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.sat       = sat_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Bench for iir_biquad_seq: pipelined multiplier model, difference-equation
// reference model with cycle-accurate handshake expectations, directed and random stimulus.
module tb_iir_biquad_seq;
  localparam int unsigned DW      = 24;
  localparam int unsigned ACC_W   = 28;
  localparam int          MUL_LAT = 15;
  localparam int          OUT_LAT = 6 + MUL_LAT;

  logic clk = 1'b0;
  logic rst;

  iir_biquad_seq_if #(.DW(DW)) bus ();

  iir_biquad_seq #(.DW(DW), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mulq(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [47:0] p;
    p = $signed(a) * $signed(b);
    return p[45:22];
  endfunction

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [DW-1:0] rnd_q();
    logic [DW-1:0] v;
    v = 24'($urandom);
    if ($urandom_range(0, 1) == 1) v = {{3{v[23]}}, v[20:0]};
    return v;
  endfunction

  // Reference model state
  int            cyc = 0;
  logic [DW-1:0] m_x1 = '0, m_x2 = '0, m_y1 = '0, m_y2 = '0;
  bit            has_acc = 1'b0;
  int            acc_cyc = 0;
  int            n_acc = 0;
  int            acc_times[$];
  logic [DW-1:0] exp_a [5];
  logic [DW-1:0] exp_b [5];
  logic [DW-1:0] exp_y = '0;
  logic          exp_sat = 1'b0;
  int            s_ref;

  // Output monitor state
  int            n_out = 0;
  logic [DW-1:0] last_y = '0;
  logic          last_sat = 1'b0;
  int            last_out_cyc = 0;

  // Reference: y[n] from the difference equation, evaluated at each acceptance.
  always @(posedge clk) begin
    if (rst) begin
      m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
      has_acc = 1'b0;
    end else if (!has_acc || cyc >= acc_cyc + OUT_LAT) begin
      if (bus.clr) begin
        m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
      end else if (bus.in_valid) begin
        s_ref = sx(mulq(bus.b0, bus.x_in)) + sx(mulq(bus.b1, m_x1)) + sx(mulq(bus.b2, m_x2))
              - sx(mulq(bus.a1, m_y1)) - sx(mulq(bus.a2, m_y2));
        exp_sat = (s_ref > 8388607) || (s_ref < -8388608);
        if (s_ref > 8388607)       exp_y = 24'h7FFFFF;
        else if (s_ref < -8388608) exp_y = 24'h800000;
        else                       exp_y = 24'(s_ref);
        exp_a[0] = bus.b0; exp_a[1] = bus.b1; exp_a[2] = bus.b2; exp_a[3] = bus.a1; exp_a[4] = bus.a2;
        exp_b[0] = bus.x_in; exp_b[1] = m_x1; exp_b[2] = m_x2; exp_b[3] = m_y1; exp_b[4] = m_y2;
        m_x2 = m_x1; m_x1 = bus.x_in; m_y2 = m_y1; m_y1 = exp_y;
        has_acc = 1'b1;
        acc_cyc = cyc;
        n_acc++;
        acc_times.push_back(cyc);
      end
    end
    cyc++;
  end

  // Per-cycle output checks, sampled mid-cycle.
  always @(negedge clk) begin
    int  k;
    bit  busy;
    if (rst) begin
      check_eq("rst_in_ready",  32'(bus.in_ready), 32'd1);
      check_eq("rst_mul_valid", 32'(bus.mul_valid), 32'd0);
      check_eq("rst_mul_a",     32'(bus.mul_a), 32'd0);
      check_eq("rst_mul_b",     32'(bus.mul_b), 32'd0);
      check_eq("rst_y_out",     32'(bus.y_out), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_sat",       32'(bus.sat), 32'd0);
    end else begin
      k    = cyc - acc_cyc - 1;
      busy = has_acc && (cyc < acc_cyc + OUT_LAT);
      check_eq("in_ready", 32'(bus.in_ready), 32'(!busy && !bus.clr));
      check_eq("mul_valid", 32'(bus.mul_valid), 32'(has_acc && k >= 0 && k < 5));
      if (has_acc && k >= 0 && k < 5) begin
        check_eq("mul_a", 32'(bus.mul_a), 32'(exp_a[k]));
        check_eq("mul_b", 32'(bus.mul_b), 32'(exp_b[k]));
      end
      check_eq("out_valid", 32'(bus.out_valid), 32'(has_acc && cyc == acc_cyc + OUT_LAT));
      if (bus.out_valid) begin
        check_eq("y_out", 32'(bus.y_out), 32'(exp_y));
        check_eq("sat",   32'(bus.sat), 32'(exp_sat));
        last_y       = bus.y_out;
        last_sat     = bus.sat;
        last_out_cyc = cyc;
        n_out++;
      end else begin
        check_eq("sat_idle", 32'(bus.sat), 32'd0);
      end
    end
  end

  // Pipelined multiplier model, MUL_LAT cycles from operand to product.
  logic [DW-1:0] pp [MUL_LAT];
  logic          pv [MUL_LAT];
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        pp[i] = '0;
        pv[i] = 1'b0;
      end
      bus.mul_p       = '0;
      bus.mul_p_valid = 1'b0;
    end else begin
      bus.mul_p       = pp[MUL_LAT-1];
      bus.mul_p_valid = pv[MUL_LAT-1];
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        pp[i] = pp[i-1];
        pv[i] = pv[i-1];
      end
      pp[0] = mulq(bus.mul_a, bus.mul_b);
      pv[0] = bus.mul_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input logic [DW-1:0] c0, input logic [DW-1:0] c1, input logic [DW-1:0] c2,
                          input logic [DW-1:0] c3, input logic [DW-1:0] c4);
    bus.b0 = c0; bus.b1 = c1; bus.b2 = c2; bus.a1 = c3; bus.a2 = c4;
  endtask

  task automatic clr_pulse();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic wait_acc(input string tag);
    int n0 = n_acc;
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_acc != n0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_out(input string tag);
    int n0 = n_out;
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (n_out != n0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_out_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] x, input string tag);
    bus.x_in     = x;
    bus.in_valid = 1'b1;
    wait_acc(tag);
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input logic [DW-1:0] x, input string tag, input logic [DW-1:0] ey, input logic es);
    send(x, tag);
    wait_out(tag);
    check_eq({tag, "_y"},   32'(last_y), 32'(ey));
    check_eq({tag, "_sat"}, 32'(last_sat), 32'(es));
    check_eq({tag, "_lat"}, 32'(last_out_cyc - acc_times[$]), 32'(OUT_LAT));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst          = 1'b1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    set_coef('0, '0, '0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single tap pass-through
    set_coef(24'h400000, '0, '0, '0, '0);
    run(24'h200000, "t1", 24'h200000, 1'b0);

    // FIR running sum
    clr_pulse();
    set_coef(24'h400000, 24'h400000, 24'h400000, '0, '0);
    run(24'h100000, "t2a", 24'h100000, 1'b0);
    run(24'h100000, "t2b", 24'h200000, 1'b0);
    run(24'h100000, "t2c", 24'h300000, 1'b0);

    // Feedback impulse response
    clr_pulse();
    set_coef(24'h400000, '0, '0, 24'h200000, '0);
    run(24'h400000, "t3a", 24'h400000, 1'b0);
    run(24'h000000, "t3b", 24'hE00000, 1'b0);
    run(24'h000000, "t3c", 24'h100000, 1'b0);

    // Positive and negative saturation
    clr_pulse();
    set_coef(24'h600000, 24'h600000, 24'h600000, '0, '0);
    run(24'h400000, "t4a", 24'h600000, 1'b0);
    run(24'h400000, "t4b", 24'h7FFFFF, 1'b1);
    clr_pulse();
    run(24'hC00000, "t5a", 24'hA00000, 1'b0);
    run(24'hC00000, "t5b", 24'h800000, 1'b1);

    // in_valid held high, clr pulsed while busy
    clr_pulse();
    set_coef(24'h400000, 24'h200000, '0, 24'h100000, '0);
    n0 = acc_times.size();
    bus.x_in     = 24'($urandom);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_acc("t6");
      bus.x_in = 24'($urandom);
      if (i == 1) begin
        repeat (5) tick();
        clr_pulse();
      end
    end
    bus.in_valid = 1'b0;
    wait_out("t6");
    check_eq("t6_acc_count", 32'(acc_times.size() - n0), 32'd4);
    for (int i = 0; i < 3; i++)
      check_eq("t6_gap", 32'(acc_times[n0+i+1] - acc_times[n0+i]), 32'(OUT_LAT));

    // clr with in_valid in IDLE: no acceptance, history cleared
    set_coef(24'h400000, 24'h400000, '0, 24'h200000, '0);
    bus.x_in     = 24'h200000;
    bus.in_valid = 1'b1;
    bus.clr      = 1'b1;
    n0 = n_acc;
    tick();
    check_eq("t7_no_accept", 32'(n_acc - n0), 32'd0);
    bus.clr = 1'b0;
    wait_acc("t7");
    bus.in_valid = 1'b0;
    wait_out("t7");
    check_eq("t7_y",   32'(last_y), 32'h200000);
    check_eq("t7_sat", 32'(last_sat), 32'd0);

    // Reset ten cycles into a sample
    send(24'h300000, "t8pre");
    repeat (9) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n0 = n_out;
    run(24'h100000, "t8", 24'h100000, 1'b0);
    check_eq("t8_single_out", 32'(n_out - n0), 32'd1);

    // Random coefficients, samples, clears and gaps
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) clr_pulse();
      set_coef(rnd_q(), rnd_q(), rnd_q(), rnd_q(), rnd_q());
      send(rnd_q(), "rnd");
      wait_out("rnd");
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
